song_player: RTL and testbench
==============================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter TICKS_PER_BEAT, default 25000: clk cycles per beat, at least 2.
REQ-002 Parameter COUNTIN_BEATS, default 4: silent beats before the first note, range 1..15.
REQ-003 clk  input  1  system clock; the block uses one clock, rising edge only.
REQ-004 nrst  input  1  reset; synchronous and active-low.
REQ-005 mode  input  3  game mode; the block is active only while mode == MODE_PLAY.
REQ-006 pause  input  1  level; freezes song time while high.
REQ-007 note1  input  32  lane-0 song bits, as written by the song editor.
REQ-008 note2  input  32  lane-1 song bits, as written by the song editor.
REQ-009 hit_ack  input  1  scorer acknowledges the currently presented note.
REQ-010 cur_note  output  2  {lane1,lane0} note for the current beat; 2'b00 means rest.
REQ-011 note_valid  output  1  current note is awaiting hit_ack.
REQ-012 lookahead  output  8  next four notes, {idx-1, idx-2, idx-3, idx-4}, 2 bits each, with idx-1 in the MSBs.
REQ-013 position  output  5  current song index (idx).
REQ-014 beat  output  1  one-cycle pulse at each beat boundary.
REQ-015 playing  output  1  high in states COUNTIN and PLAY.
REQ-016 miss  output  1  one-cycle pulse when a note expires without hit_ack.
REQ-017 song_done  output  1  level; high in state DONE.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, COUNTIN, PLAY and DONE.
REQ-019 IDLE SHALL go to LOAD on the cycle after mode == MODE_PLAY is sampled.
REQ-020 LOAD SHALL last one cycle and SHALL:
- snapshot note1/note2 into internal registers;
- set idx = 31, divider = 0 and beat count = 0;
- go to COUNTIN.
REQ-021 Divider behaviour in COUNTIN/PLAY with pause low:
- the divider counts 0..TICKS_PER_BEAT-1 and wraps;
- the cycle with divider == TICKS_PER_BEAT-1 is the beat boundary;
- beat SHALL pulse in that cycle.
REQ-022 COUNTIN SHALL count boundaries; at the COUNTIN_BEATS-th boundary it SHALL go to PLAY presenting idx 31.
REQ-023 In PLAY:
- cur_note SHALL equal {snap2[idx], snap1[idx]};
- note_valid SHALL be set at note presentation when cur_note != 2'b00, else cleared.
REQ-024 hit_ack while note_valid SHALL clear note_valid on the next cycle; hit_ack while note_valid is low SHALL be ignored.
REQ-025 At a PLAY boundary with note_valid still high and no hit_ack in that cycle, miss SHALL pulse for that cycle.
REQ-026 hit_ack coincident with a boundary SHALL count as a hit (no miss pulse).
REQ-027 At a PLAY boundary, advancement:
- idx > 0: idx SHALL decrement and the next note SHALL be presented on the following cycle;
- idx == 0: the FSM SHALL go to DONE;
- idx SHALL never wrap.
REQ-028 lookahead entries for indices below 0 SHALL be 2'b00.
REQ-029 While pause is high:
- the divider, idx and beat count SHALL hold;
- beat and miss SHALL stay low;
- hit_ack SHALL be ignored.
REQ-030 DONE SHALL hold song_done high and playing low until mode != MODE_PLAY, then go to IDLE.
REQ-031 mode != MODE_PLAY sampled in any state SHALL return the FSM to IDLE on the next cycle, with all outputs at reset values.
REQ-032 Changes to note1/note2 after LOAD SHALL NOT affect playback.
REQ-033 In IDLE and LOAD, cur_note, lookahead and position SHALL be 0.

Reset
REQ-034 When nrst is low at a rising clk edge, the state SHALL become IDLE and the divider, idx, beat count and snapshots SHALL become 0.
REQ-035 After reset, every output SHALL read 0.
REQ-036 Reset mid-song SHALL abort playback with no miss or song_done pulse.

Structure
REQ-037 The shared package game_pkg SHALL hold:
- MODE_EDIT = 3'd2 and MODE_PLAY = 3'd3;
- the player state enum;
- NOTE_REST = 2'b00.
REQ-038 The beat divider SHALL be sub-module beat_timer, with inputs enable and clear and output a boundary pulse.

Verification
REQ-039 Run with TICKS_PER_BEAT = 4 and COUNTIN_BEATS = 2. Load note1 = 32'h80000000, note2 = 0, and set mode = MODE_PLAY. Required: 2 beat pulses, then PLAY with cur_note = 2'b01, note_valid = 1 and position = 31.
REQ-040 Same setup, with hit_ack one cycle after presentation. Required: note_valid = 0 next cycle and no miss at the boundary.
REQ-041 Same setup, no hit_ack. Required: miss pulses exactly at the boundary cycle, and position becomes 30.
REQ-042 Full song of 32 beats. Required: song_done rises after the idx 0 boundary, and exactly 32 PLAY beat pulses are seen.
REQ-043 Hold pause high for 10 cycles mid-beat. Required: position and divider unchanged, and the boundary is delayed by exactly 10 cycles.
REQ-044 Switch mode to MODE_EDIT mid-PLAY. Required: next cycle IDLE, all outputs 0, and rewriting note1 does not alter a subsequent replay until LOAD.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide constants, player FSM states and song bit lookup.
// Both lanes of a song are 32-bit vectors indexed by song position.
package game_pkg;

    localparam logic [2:0] MODE_EDIT = 3'd2;
    localparam logic [2:0] MODE_PLAY = 3'd3;
    localparam logic [1:0] NOTE_REST = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNTIN,
        ST_PLAY,
        ST_DONE
    } player_state_e;

    // Returns {lane1, lane0} at position idx; positions outside 0..31 are rests.
    function automatic logic [1:0] song_note(input logic [31:0] lane0,
                                             input logic [31:0] lane1,
                                             input int          idx);
        logic [4:0] pos;
        if (idx < 0 || idx > 31) begin
            return NOTE_REST;
        end
        pos = idx[4:0];
        return {lane1[pos], lane0[pos]};
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat divider: counts 0..TICKS_PER_BEAT-1 while enabled and flags the last
// count of each beat. clear has priority and holds the count at zero.
module beat_timer #(
    parameter int TICKS_PER_BEAT = 25000
) (
    input  logic clk,
    input  logic nrst,
    input  logic enable,
    input  logic clear,
    output logic boundary
);

    localparam int CW = (TICKS_PER_BEAT > 2) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BEAT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boundary = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/song_player.sv
// Rhythm-game song player: snapshots a 32-step two-lane song, counts in,
// then presents one note per beat from index 31 down to 0, flagging misses.
module song_player
    import game_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25000,
    parameter int COUNTIN_BEATS  = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [2:0]  mode,
    input  logic        pause,
    input  logic [31:0] note1,
    input  logic [31:0] note2,
    input  logic        hit_ack,
    output logic [1:0]  cur_note,
    output logic        note_valid,
    output logic [7:0]  lookahead,
    output logic [4:0]  position,
    output logic        beat,
    output logic        playing,
    output logic        miss,
    output logic        song_done
);

    localparam logic [3:0] LAST_COUNTIN = 4'(COUNTIN_BEATS - 1);

    player_state_e state_q;
    logic [31:0]   snap1_q;
    logic [31:0]   snap2_q;
    logic [4:0]    idx_q;
    logic [3:0]    cbeat_q;
    logic [1:0]    cur_note_q;
    logic          note_valid_q;

    logic          active;
    logic          running;
    logic          tick;
    logic [1:0]    first_note_d;
    logic [1:0]    next_note_d;

    // Nothing advances while in reset or outside play mode, so an abort
    // can never emit a stray beat or miss.
    assign active  = nrst && (mode == MODE_PLAY);
    assign running = (state_q == ST_COUNTIN) || (state_q == ST_PLAY);

    beat_timer #(
        .TICKS_PER_BEAT(TICKS_PER_BEAT)
    ) u_beat_timer (
        .clk     (clk),
        .nrst    (nrst),
        .enable  (active && running && !pause),
        .clear   (!running),
        .boundary(tick)
    );

    assign first_note_d = song_note(snap1_q, snap2_q, 31);
    assign next_note_d  = song_note(snap1_q, snap2_q, int'(idx_q) - 1);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            snap1_q      <= '0;
            snap2_q      <= '0;
            idx_q        <= '0;
            cbeat_q      <= '0;
            cur_note_q   <= NOTE_REST;
            note_valid_q <= 1'b0;
        end else if (mode != MODE_PLAY) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cbeat_q      <= '0;
            cur_note_q   <= NOTE_REST;
            note_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    snap1_q <= note1;
                    snap2_q <= note2;
                    idx_q   <= 5'd31;
                    cbeat_q <= '0;
                    state_q <= ST_COUNTIN;
                end
                ST_COUNTIN: begin
                    if (tick) begin
                        if (cbeat_q == LAST_COUNTIN) begin
                            state_q      <= ST_PLAY;
                            cur_note_q   <= first_note_d;
                            note_valid_q <= (first_note_d != NOTE_REST);
                        end else begin
                            cbeat_q <= cbeat_q + 4'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    // A boundary always moves on; a hit in that same cycle
                    // only matters for suppressing the miss pulse.
                    if (tick) begin
                        if (idx_q == 5'd0) begin
                            state_q      <= ST_DONE;
                            cur_note_q   <= NOTE_REST;
                            note_valid_q <= 1'b0;
                        end else begin
                            idx_q        <= idx_q - 5'd1;
                            cur_note_q   <= next_note_d;
                            note_valid_q <= (next_note_d != NOTE_REST);
                        end
                    end else if (hit_ack && !pause) begin
                        note_valid_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cur_note   = cur_note_q;
    assign note_valid = note_valid_q;
    assign position   = idx_q;
    assign lookahead  = running ? {song_note(snap1_q, snap2_q, int'(idx_q) - 1),
                                   song_note(snap1_q, snap2_q, int'(idx_q) - 2),
                                   song_note(snap1_q, snap2_q, int'(idx_q) - 3),
                                   song_note(snap1_q, snap2_q, int'(idx_q) - 4)}
                                : 8'd0;
    assign beat       = tick;
    assign miss       = tick && (state_q == ST_PLAY) && note_valid_q && !hit_ack;
    assign playing    = running;
    assign song_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player: a timeline model predicts every beat
// boundary and the cycle after it; a negedge monitor compares on each beat.
module tb_song_player;
    import game_pkg::*;

    localparam int T = 4;
    localparam int C = 2;

    logic        clk = 1'b0;
    logic        nrst;
    logic [2:0]  mode;
    logic        pause;
    logic [31:0] note1;
    logic [31:0] note2;
    logic        hit_ack;
    logic [1:0]  cur_note;
    logic        note_valid;
    logic [7:0]  lookahead;
    logic [4:0]  position;
    logic        beat;
    logic        playing;
    logic        miss;
    logic        song_done;

    song_player #(
        .TICKS_PER_BEAT(T),
        .COUNTIN_BEATS (C)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .mode      (mode),
        .pause     (pause),
        .note1     (note1),
        .note2     (note2),
        .hit_ack   (hit_ack),
        .cur_note  (cur_note),
        .note_valid(note_valid),
        .lookahead (lookahead),
        .position  (position),
        .beat      (beat),
        .playing   (playing),
        .miss      (miss),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [4:0] pos;
        logic [1:0] cur;
        logic       nv;
        logic       miss;
        logic [7:0] la;
        logic       chk_la;
        logic       playing;
        logic       done;
    } exp_t;

    exp_t bnd_q[$];
    exp_t post_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   post_pend = 1'b0;

    // Song configuration seen by the model.
    logic [31:0] s1, s2;
    int hit_h[32];
    int hit2[32];
    int pa, pl, w0;

    function automatic logic [1:0] ref_note(int i);
        logic [4:0] k;
        if (i < 0) return 2'b00;
        k = i[4:0];
        return {s2[k], s1[k]};
    endfunction

    // Wall-clock interval of the a-th unpaused running cycle.
    function automatic int wall(int a);
        return w0 + a + ((pl > 0 && a >= pa) ? pl : 0);
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(string name, exp_t e);
        logic ok;
        tests++;
        ok = (cyc == e.cyc) && (position === e.pos) && (cur_note === e.cur) &&
             (note_valid === e.nv) && (miss === e.miss) && (playing === e.playing) &&
             (song_done === e.done) && (!e.chk_la || lookahead === e.la);
        if (!ok) begin
            fails++;
            $display("FAIL %s: got cyc=%0d pos=%0d cur=%b nv=%b miss=%b la=%h playing=%b done=%b; expected cyc=%0d pos=%0d cur=%b nv=%b miss=%b la=%h(chk=%b) playing=%b done=%b",
                     name, cyc, position, cur_note, note_valid, miss, lookahead, playing, song_done,
                     e.cyc, e.pos, e.cur, e.nv, e.miss, e.la, e.chk_la, e.playing, e.done);
        end
    endtask

    task automatic check_zero(string name);
        tests++;
        if ({cur_note, note_valid, lookahead, position, beat, playing, miss, song_done} !== 20'd0) begin
            fails++;
            $display("FAIL %s: got cur=%b nv=%b la=%h pos=%0d beat=%b playing=%b miss=%b done=%b; expected all zero",
                     name, cur_note, note_valid, lookahead, position, beat, playing, miss, song_done);
        end
    endtask

    // Monitor: each beat pulse and the cycle after it consume one record.
    always @(negedge clk) begin
        exp_t e;
        if (post_pend) begin
            if (post_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL post_unexpected: got pos=%0d cur=%b at cyc=%0d; expected no record", position, cur_note, cyc);
            end else begin
                e = post_q.pop_front();
                compare("after_boundary", e);
            end
        end
        if (beat === 1'b1) begin
            if (bnd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL beat_unexpected: got beat=1 at cyc=%0d; expected no beat", cyc);
            end else begin
                e = bnd_q.pop_front();
                compare("boundary", e);
            end
        end else if (miss !== 1'b0) begin
            tests++; fails++;
            $display("FAIL miss_without_beat: got miss=%b at cyc=%0d; expected 0", miss, cyc);
        end
        post_pend = (beat === 1'b1);
    end

    task automatic clear_hits();
        for (int j = 0; j < 32; j++) begin
            hit_h[j] = -1;
            hit2[j]  = 0;
        end
    endtask

    task automatic rand_hits(int pct);
        for (int j = 0; j < 32; j++) begin
            hit_h[j] = ($urandom_range(99) < pct) ? int'($urandom_range(T - 1)) : -1;
            hit2[j]  = int'($urandom_range(T - 1));
        end
    endtask

    task automatic push_rec(exp_t e, bit is_post, int abort_w);
        if (is_post) begin
            if (abort_w < 0 || e.cyc <= abort_w) post_q.push_back(e);
        end else begin
            if (abort_w < 0 || e.cyc < abort_w) bnd_q.push_back(e);
        end
    endtask

    task automatic plan_song(int abort_w);
        exp_t e;
        int a, idx;
        logic [1:0] n;
        for (int k = 1; k <= C; k++) begin
            a = k * T - 1;
            e = '0;
            e.cyc = wall(a); e.pos = 5'd31; e.playing = 1'b1;
            push_rec(e, 1'b0, abort_w);
            e.cyc = wall(a) + 1;
            if (k == C) begin
                e.cur = ref_note(31);
                e.nv  = (ref_note(31) != 2'b00);
            end
            push_rec(e, 1'b1, abort_w);
        end
        for (int j = 0; j < 32; j++) begin
            idx = 31 - j;
            a   = C * T + j * T + T - 1;
            n   = ref_note(idx);
            e = '0;
            e.cyc = wall(a); e.pos = 5'(idx); e.cur = n;
            e.nv   = (n != 2'b00) && !(hit_h[j] >= 0 && hit_h[j] < T - 1);
            e.miss = (n != 2'b00) && (hit_h[j] < 0);
            e.la = {ref_note(idx - 1), ref_note(idx - 2), ref_note(idx - 3), ref_note(idx - 4)};
            e.chk_la = 1'b1; e.playing = 1'b1;
            push_rec(e, 1'b0, abort_w);
            e = '0;
            e.cyc = wall(a) + 1;
            if (idx > 0) begin
                e.pos = 5'(idx - 1); e.cur = ref_note(idx - 1);
                e.nv = (ref_note(idx - 1) != 2'b00); e.playing = 1'b1;
            end else begin
                e.done = 1'b1;
            end
            push_rec(e, 1'b1, abort_w);
        end
    endtask

    task automatic drive(int w);
        int a, j, h;
        bit paused;
        paused  = (pl > 0) && (w >= w0 + pa) && (w < w0 + pa + pl);
        pause   = paused;
        hit_ack = 1'b0;
        if (w >= w0) begin
            note1 = $urandom();
            note2 = $urandom();
        end
        if (paused) begin
            hit_ack = 1'($urandom_range(1));
        end else if (w >= w0) begin
            a = w - w0 - ((pl > 0 && w >= w0 + pa + pl) ? pl : 0);
            if (a >= C * T) begin
                j = (a - C * T) / T;
                h = (a - C * T) % T;
                if (j < 32)
                    hit_ack = (hit_h[j] == h) || (hit_h[j] >= 0 && hit2[j] > hit_h[j] && hit2[j] == h);
            end
        end
    endtask

    task automatic run_song(string tag, input logic [31:0] n1v, input logic [31:0] n2v,
                            input int abort_off, input bit abort_rst);
        int abort_w, end_w;
        s1 = n1v; s2 = n2v;
        note1 = n1v; note2 = n2v;
        mode = MODE_EDIT; pause = 1'b0; hit_ack = 1'b0;
        next(); next();
        mode = MODE_PLAY;
        w0 = cyc + 2;
        abort_w = (abort_off >= 0) ? w0 + abort_off : -1;
        plan_song(abort_w);
        end_w = (abort_off >= 0) ? abort_w - 1 : wall(C * T + 32 * T) + 3;
        while (cyc < end_w) begin
            next();
            drive(cyc);
        end
        if (abort_off >= 0) begin
            next();
            hit_ack = 1'b0; pause = 1'b0;
            if (abort_rst) nrst = 1'b0;
            else mode = MODE_EDIT;
            next();
            nrst = 1'b1; mode = MODE_EDIT;
            check_zero({tag, "_abort_idle"});
        end else begin
            tests++;
            if (song_done !== 1'b1 || playing !== 1'b0 || position !== 5'd0) begin
                fails++;
                $display("FAIL %s_done_hold: got done=%b playing=%b pos=%0d; expected done=1 playing=0 pos=0",
                         tag, song_done, playing, position);
            end
            mode = MODE_EDIT; hit_ack = 1'b0; pause = 1'b0;
            next();
            check_zero({tag, "_exit_idle"});
        end
        tests++;
        if (bnd_q.size() != 0 || post_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d boundary and %0d post records left; expected 0 and 0",
                     tag, bnd_q.size(), post_q.size());
            bnd_q.delete();
            post_q.delete();
        end
    endtask

    initial begin
        nrst = 1'b0; mode = MODE_EDIT; pause = 1'b0; hit_ack = 1'b0;
        note1 = '0; note2 = '0;
        s1 = '0; s2 = '0; pa = 0; pl = 0; w0 = 0;
        clear_hits();
        repeat (3) next();
        check_zero("reset");
        nrst = 1'b1;
        next();
        check_zero("idle_after_reset");

        clear_hits(); hit_h[0] = 1; pl = 0;
        run_song("first_hit", 32'h8000_0000, 32'h0, -1, 1'b0);

        clear_hits(); pl = 0;
        run_song("first_miss", 32'h8000_0000, 32'h0, -1, 1'b0);

        rand_hits(60); pl = 10; pa = C * T + 5 * T + 1;
        run_song("pause10", $urandom(), $urandom(), -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_hits(50);
            pl = int'($urandom_range(12));
            pa = int'($urandom_range(C * T + 32 * T - 1));
            run_song("random", $urandom(), $urandom(), -1, 1'b0);
        end

        rand_hits(50); pl = 0;
        run_song("mode_abort", $urandom(), $urandom(), C * T + 6 * T + 2, 1'b0);

        clear_hits(); pl = 0;
        run_song("reset_abort", 32'hFFFF_FFFF, $urandom(), C * T + 3 * T + T - 1, 1'b1);

        rand_hits(70); pl = 0;
        run_song("replay", $urandom(), $urandom(), -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 time units; expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
